tx_arb: RTL
===========

TX_ARB -- requirements
Module: tx_arb

Interface
REQ-001 Parameter GAP_CYCLES, default 16: idle clk cycles enforced after every transmitted byte (legal 1..255).
REQ-002 clk  input  1  system clock; all flops on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 send_resp  input  1  one-cycle pulse from the command unit: a response byte is ready.
REQ-005 resp  input  8  response byte, valid in the send_resp cycle.
REQ-006 tel_req  input  1  telemetry frame request, level, held until tel_ack.
REQ-007 tel_data  input  16  telemetry word, stable while tel_req=1.
REQ-008 tx_done  input  1  UART transmitter: current byte finished (one-cycle pulse).
REQ-009 clr_ovr  input  1  clears resp_ovr.
REQ-010 trmt  output  1  one-cycle pulse starting a UART byte.
REQ-011 tx_data  output  8  byte to UART, held from trmt until tx_done.
REQ-012 tel_ack  output  1  one-cycle pulse: telemetry frame fully sent.
REQ-013 resp_ovr  output  1  sticky: a pending response was overwritten.
REQ-014 busy  output  1  high in every state except IDLE.

Function
REQ-015 A one-deep response buffer (resp_pend, resp_buf) SHALL capture resp on send_resp.
REQ-016 A send_resp while resp_pend=1 and the buffer is not issued that cycle SHALL overwrite resp_buf with the new byte and set resp_ovr.
REQ-017 A send_resp in the same cycle the buffer is issued SHALL leave resp_pend=1 holding the new byte, with no overrun.
REQ-018 States: IDLE, RESP_TX, TEL_HI, TEL_LO, GAP.
REQ-019 IDLE, only resp_pend: trmt=1, tx_data=resp_buf, clear resp_pend, last_grant=RESP, go RESP_TX.
REQ-020 IDLE, only tel_req: capture tel_data into tel_buf, trmt=1, tx_data=tel_buf[15:8], last_grant=TEL, go TEL_HI.
REQ-021 IDLE with both pending: grant the requester not equal to last_grant (round-robin).
REQ-022 RESP_TX/TEL_HI/TEL_LO: hold tx_data; on tx_done load the gap counter with GAP_CYCLES-1 and go GAP.
REQ-023 GAP: decrement the counter; at zero go to TEL_LO if the previous byte was the high byte, else IDLE.
REQ-024 Entry to TEL_LO SHALL pulse trmt with tx_data=tel_buf[7:0].
REQ-025 tel_ack SHALL pulse in the cycle tx_done is seen in TEL_LO.
REQ-026 A telemetry frame is atomic: a response arriving mid-frame waits until the frame's final GAP ends.
REQ-027 A response arriving in any state is never lost, except by overwrite per REQ-016.
REQ-028 tx_done in IDLE or GAP SHALL be ignored.
REQ-029 Throughput: a frame occupies 2 bytes plus 2*GAP_CYCLES cycles plus UART time.
REQ-030 Arbitration SHALL be decided in the IDLE cycle, and trmt SHALL issue in that same cycle.
REQ-031 Deassertion of tel_req before tel_ack is illegal; the in-flight frame SHALL still complete.
REQ-032 clr_ovr clears resp_ovr; if set and clear coincide, set wins.

Reset
REQ-033 On rst_n low: state=IDLE, resp_pend=0, resp_buf=0, tel_buf=0, gap counter=0, last_grant=TEL (the first contest goes to the response).
REQ-034 On rst_n low: trmt=0, tx_data=0, tel_ack=0, resp_ovr=0, busy=0.
REQ-035 Reset mid-byte SHALL abandon the byte with no tel_ack, and the next grant SHALL follow REQ-019..021.

Structure
REQ-036 Shared package SHALL hold the state enum, the grant enum {RESP, TEL} and the default GAP_CYCLES constant.
REQ-037 Gap counter width SHALL be 8 bits.
REQ-038 Gap counting SHALL be a sub-module tx_gap_tmr (load, dec, zero flag); all other logic stays in tx_arb.

Verification
REQ-039 Response alone: send_resp with resp=8'hA5 in IDLE -> trmt the same cycle, tx_data=8'hA5, GAP then IDLE after tx_done; no tel_ack.
REQ-040 Telemetry alone: tel_data=16'h1234 -> bytes 8'h12 then 8'h34 separated by exactly GAP_CYCLES idle cycles, then one tel_ack.
REQ-041 Both pending out of reset, resp=8'h55, tel_data=16'hBEEF -> 8'h55 first, then 8'hBE, 8'hEF.
REQ-042 Round-robin with tel_req held continuously and send_resp repeated after each grant -> bytes strictly alternate response / telemetry frame.
REQ-043 During TEL_HI, send_resp 8'h01 then 8'h02 -> resp_ovr=1, only 8'h02 sent, and only after TEL_LO's gap; clr_ovr then clears resp_ovr.
REQ-044 rst_n asserted during TEL_LO -> all outputs 0, no tel_ack, and a fresh tel_req restarts with the high byte.

Source files
------------

// File: rtl/tx_arb_pkg.sv
// tx_arb_pkg: shared types and defaults for the UART transmit arbiter
package tx_arb_pkg;
    typedef enum logic [2:0] {IDLE, RESP_TX, TEL_HI, TEL_LO, GAP} state_t;
    typedef enum logic {RESP, TEL} grant_t;
    localparam int GAP_CYCLES_DEF = 16;
endpackage

// File: rtl/tx_gap_tmr.sv
// tx_gap_tmr: loadable 8-bit down counter that flags zero
module tx_gap_tmr (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic       dec,
    input  logic [7:0] load_val,
    output logic       zero
);
    logic [7:0] cnt;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt <= '0;
        else if (load) cnt <= load_val;
        else if (dec && cnt != 8'd0) cnt <= cnt - 8'd1;
    assign zero = cnt == 8'd0;
endmodule

// File: rtl/tx_arb.sv
// tx_arb: round-robin arbiter sharing one UART between responses and 2-byte telemetry frames
module tx_arb import tx_arb_pkg::*; #(
    parameter int GAP_CYCLES = GAP_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        send_resp,
    input  logic [7:0]  resp,
    input  logic        tel_req,
    input  logic [15:0] tel_data,
    input  logic        tx_done,
    input  logic        clr_ovr,
    output logic        trmt,
    output logic [7:0]  tx_data,
    output logic        tel_ack,
    output logic        resp_ovr,
    output logic        busy
);
    state_t      state;
    grant_t      last_grant;
    logic        resp_pend, to_lo, lo_start, gap_zero;
    logic        idle, resp_rq, pick_tel, pick_resp, tx_end;
    logic [7:0]  resp_buf, resp_tx, resp_byte, held;
    logic [15:0] tel_buf;
    // a response arriving in an IDLE cycle is bypassed straight to the UART
    assign idle      = rst_n && state == IDLE;
    assign resp_rq   = resp_pend || send_resp;
    assign resp_byte = resp_pend ? resp_buf : resp;
    assign pick_tel  = idle && tel_req && (!resp_rq || last_grant == RESP);
    assign pick_resp = idle && resp_rq && !pick_tel;
    assign tx_end    = tx_done && (state == RESP_TX || state == TEL_HI || state == TEL_LO);
    assign held      = last_grant == RESP ? resp_tx :
                       (state == TEL_HI || (state == GAP && to_lo)) ? tel_buf[15:8] : tel_buf[7:0];
    assign trmt      = pick_tel || pick_resp || lo_start;
    assign tx_data   = pick_tel ? tel_data[15:8] : pick_resp ? resp_byte : held;
    assign tel_ack   = tx_done && state == TEL_LO;
    assign busy      = state != IDLE;
    tx_gap_tmr u_gap (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tx_end),
        .dec      (state == GAP),
        .load_val (8'(GAP_CYCLES - 1)),
        .zero     (gap_zero)
    );
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= TEL;
            tel_buf    <= '0;
            resp_tx    <= '0;
            to_lo      <= 1'b0;
            lo_start   <= 1'b0;
        end else begin
            lo_start <= 1'b0;
            case (state)
                IDLE:
                    if (pick_tel) begin
                        tel_buf    <= tel_data;
                        last_grant <= TEL;
                        state      <= TEL_HI;
                    end else if (pick_resp) begin
                        resp_tx    <= resp_byte;
                        last_grant <= RESP;
                        state      <= RESP_TX;
                    end
                RESP_TX, TEL_HI, TEL_LO:
                    if (tx_done) begin
                        to_lo <= state == TEL_HI;
                        state <= GAP;
                    end
                GAP:
                    if (gap_zero) begin
                        state    <= to_lo ? TEL_LO : IDLE;
                        lo_start <= to_lo;
                    end
                default: state <= IDLE;
            endcase
        end
    // a byte issued by bypass never enters the buffer; set beats clear on resp_ovr
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            resp_pend <= 1'b0;
            resp_buf  <= '0;
            resp_ovr  <= 1'b0;
        end else begin
            if (send_resp && !(pick_resp && !resp_pend)) begin
                resp_buf  <= resp;
                resp_pend <= 1'b1;
            end else if (pick_resp) begin
                resp_pend <= 1'b0;
            end
            resp_ovr <= (send_resp && resp_pend && !pick_resp) || (resp_ovr && !clr_ovr);
        end
endmodule
